// File: rtl/pc_sequencer_if.sv
// Interface between the datapath/decoder and the PC sequencer.
// The master drives the op stream; the slave is the sequencer itself.
interface pc_sequencer_if;
    logic       op_valid;
    logic [2:0] op;
    logic [7:0] target;
    logic       zero;
    logic       stall;
    logic       resume;
    logic [7:0] pc_next;
    logic [7:0] pc_cur;
    logic [1:0] state;
    logic       halted;
    logic       stack_err;

    modport master (
        output op_valid, op, target, zero, stall, resume,
        input  pc_next, pc_cur, state, halted, stack_err
    );

    modport slave (
        input  op_valid, op, target, zero, stall, resume,
        output pc_next, pc_cur, state, halted, stack_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with jump/branch, HALT/resume and an optional
// return-address stack built only when PC_SEQ_STACK_EN is defined.
module pc_sequencer #(
    parameter int STACK_DEPTH = 4
) (
    input logic           clk,
    input logic           reset,
    pc_sequencer_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HALT = 2'b10;

    localparam logic [2:0] OP_NEXT = 3'b000;
    localparam logic [2:0] OP_JUMP = 3'b001;
    localparam logic [2:0] OP_BRZ  = 3'b010;
    localparam logic [2:0] OP_BRNZ = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;

    // Power-up values match the reset values.
    logic [7:0] pc_r     = 8'h00;
    logic [1:0] state_r  = ST_IDLE;
    logic       halted_r = 1'b0;

    logic [1:0] state_s;
    logic [7:0] pc_next_s;
    logic [7:0] pc_inc_s;
    logic       active_s;
    logic       call_ok_s;
    logic       ret_ok_s;
    logic [7:0] top_data_s;

    assign pc_inc_s = pc_r + 8'd1;
    assign active_s = (state_r == ST_RUN) && !bus.stall && bus.op_valid;

`ifdef PC_SEQ_STACK_EN
    localparam int         IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [3:0] DEPTH_C = 4'(STACK_DEPTH);

    logic [7:0]       stack_r [STACK_DEPTH];
    logic [3:0]       count_r     = 4'd0;
    logic             stack_err_r = 1'b0;
    logic             push_s;
    logic             pop_s;
    logic             err_set_s;
    logic [IDX_W-1:0] push_idx_s;
    logic [IDX_W-1:0] pop_idx_s;

    assign call_ok_s  = (count_r != DEPTH_C);
    assign ret_ok_s   = (count_r != 4'd0);
    assign push_idx_s = IDX_W'(count_r);
    assign pop_idx_s  = IDX_W'(count_r - 4'd1);
    assign top_data_s = stack_r[pop_idx_s];
    assign push_s     = active_s && (bus.op == OP_CALL) && call_ok_s;
    assign pop_s      = active_s && (bus.op == OP_RET) && ret_ok_s;
    assign err_set_s  = active_s && (((bus.op == OP_CALL) && !call_ok_s) ||
                                     ((bus.op == OP_RET) && !ret_ok_s));

    // Occupancy and sticky error; reset discards any push/pop in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r     <= 4'd0;
            stack_err_r <= 1'b0;
        end else begin
            if (push_s) begin
                count_r <= count_r + 4'd1;
            end else if (pop_s) begin
                count_r <= count_r - 4'd1;
            end
            if (err_set_s) begin
                stack_err_r <= 1'b1;
            end
        end
    end

    // Return-address storage; contents above occupancy are don't-care.
    always_ff @(posedge clk) begin
        if (!reset && push_s) begin
            stack_r[push_idx_s] <= pc_inc_s;
        end
    end

    assign bus.stack_err = stack_err_r;
`else
    assign call_ok_s     = 1'b0;
    assign ret_ok_s      = 1'b0;
    assign top_data_s    = 8'h00;
    assign bus.stack_err = 1'b0;
`endif

    // State, PC and halted registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            pc_r     <= 8'h00;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_next_s;
            halted_r <= (state_s == ST_HALT);
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: state_s = ST_RUN;
            ST_RUN: begin
                if (active_s && (bus.op == OP_HALT)) begin
                    state_s = ST_HALT;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_HALT: begin
                if (bus.resume) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_HALT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // PC selection: reset, then state, then stall/bubble, then op.
    always_comb begin
        pc_next_s = pc_r;
        if (reset) begin
            pc_next_s = 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: pc_next_s = pc_r;
                ST_RUN: begin
                    if (!active_s) begin
                        pc_next_s = pc_r;
                    end else begin
                        case (bus.op)
                            OP_NEXT: pc_next_s = pc_inc_s;
                            OP_JUMP: pc_next_s = bus.target;
                            OP_BRZ:  pc_next_s = bus.zero ? bus.target : pc_inc_s;
                            OP_BRNZ: pc_next_s = bus.zero ? pc_inc_s : bus.target;
                            OP_CALL: pc_next_s = call_ok_s ? bus.target : pc_inc_s;
                            OP_RET:  pc_next_s = ret_ok_s ? top_data_s : pc_inc_s;
                            OP_HALT: pc_next_s = pc_r;
                            default: pc_next_s = pc_inc_s;
                        endcase
                    end
                end
                ST_HALT: begin
                    if (bus.resume) begin
                        pc_next_s = pc_inc_s;
                    end else begin
                        pc_next_s = pc_r;
                    end
                end
                default: pc_next_s = pc_r;
            endcase
        end
    end

    assign bus.pc_next = pc_next_s;
    assign bus.pc_cur  = pc_r;
    assign bus.state   = state_r;
    assign bus.halted  = halted_r;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed ops push expected post-edge
// state into a queue that a negedge monitor pops and compares.
module tb_pc_sequencer;
    localparam logic [2:0] NX = 3'b000, JP = 3'b001, BZ = 3'b010, BN = 3'b011;
    localparam logic [2:0] CL = 3'b100, RT = 3'b101, HL = 3'b110, RS = 3'b111;
    localparam logic [1:0] SI = 2'b00, SR = 2'b01, SH = 2'b10;

    typedef struct {
        logic [7:0] pc;
        logic [1:0] st;
        logic       h;
        logic       e;
        string      nm;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    pc_sequencer_if bus ();

    pc_sequencer #(.STACK_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Monitor: one expected record per clock edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_checks++;
            if (bus.pc_cur !== e.pc || bus.state !== e.st ||
                bus.halted !== e.h || bus.stack_err !== e.e) begin
                n_fail++;
                $display("FAIL %s: got pc_cur=%h state=%b halted=%b stack_err=%b, want pc_cur=%h state=%b halted=%b stack_err=%b",
                         e.nm, bus.pc_cur, bus.state, bus.halted, bus.stack_err,
                         e.pc, e.st, e.h, e.e);
            end
        end
    end

    task automatic step(input logic r, input logic v, input logic [2:0] o,
                        input logic [7:0] t, input logic z, input logic s,
                        input logic rs, input logic [7:0] epc,
                        input logic [1:0] est, input logic ee, input string nm);
        exp_t e;
        reset        = r;
        bus.op_valid = v;
        bus.op       = o;
        bus.target   = t;
        bus.zero     = z;
        bus.stall    = s;
        bus.resume   = rs;
        e.pc = epc; e.st = est; e.h = (est == SH); e.e = ee; e.nm = nm;
        sb_q.push_back(e);
        #1;
        if (r) begin
            n_checks++;
            if (bus.pc_next !== 8'h00) begin
                n_fail++;
                $display("FAIL %s_pc_next: got %h want 00", nm, bus.pc_next);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic op1(input logic [2:0] o, input logic [7:0] t,
                       input logic [7:0] epc, input logic ee, input string nm);
        step(1'b0, 1'b1, o, t, 1'b0, 1'b0, 1'b0, epc, SR, ee, nm);
    endtask

    initial begin
        // Reset and leaving IDLE.
        step(1'b1, 1'b1, NX, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, SI, 1'b0, "reset0");
        step(1'b1, 1'b1, CL, 8'h80, 1'b0, 1'b0, 1'b0, 8'h00, SI, 1'b0, "reset1");
        op1(NX, 8'h00, 8'h00, 1'b0, "idle_exit");
        op1(NX, 8'h00, 8'h01, 1'b0, "next1");
        op1(NX, 8'h00, 8'h02, 1'b0, "next2");
        op1(NX, 8'h00, 8'h03, 1'b0, "next3");
        // Jump, wrap, branches.
        op1(JP, 8'hFE, 8'hFE, 1'b0, "jump_fe");
        op1(NX, 8'h00, 8'hFF, 1'b0, "next_ff");
        op1(NX, 8'h00, 8'h00, 1'b0, "wrap");
        op1(BZ, 8'h40, 8'h01, 1'b0, "brz_nt");
        op1(BN, 8'h40, 8'h40, 1'b0, "brnz_t");
        step(1'b0, 1'b1, BZ, 8'h50, 1'b1, 1'b0, 1'b0, 8'h50, SR, 1'b0, "brz_t");
        step(1'b0, 1'b1, BN, 8'h60, 1'b1, 1'b0, 1'b0, 8'h51, SR, 1'b0, "brnz_nt");
        // Bubble, stall priority, reserved op, resume ignored in RUN.
        step(1'b0, 1'b0, JP, 8'h77, 1'b0, 1'b0, 1'b0, 8'h51, SR, 1'b0, "bubble");
        step(1'b0, 1'b1, JP, 8'h33, 1'b0, 1'b1, 1'b0, 8'h51, SR, 1'b0, "stall_jump");
        op1(JP, 8'h33, 8'h33, 1'b0, "jump_33");
        op1(RS, 8'h99, 8'h34, 1'b0, "reserved");
        step(1'b0, 1'b1, NX, 8'h00, 1'b0, 1'b0, 1'b1, 8'h35, SR, 1'b0, "resume_run");
        // HALT, hold five cycles with ops and stall ignored, resume.
        op1(JP, 8'h20, 8'h20, 1'b0, "jump_20");
        step(1'b0, 1'b1, HL, 8'h00, 1'b0, 1'b0, 1'b0, 8'h20, SH, 1'b0, "halt");
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, JP, 8'h55, 1'b0, 1'(i % 2), 1'b0, 8'h20, SH, 1'b0, "halt_hold");
        end
        step(1'b0, 1'b1, JP, 8'h55, 1'b0, 1'b0, 1'b1, 8'h21, SR, 1'b0, "resume");
        op1(JP, 8'h10, 8'h10, 1'b0, "jump_10");
`ifdef PC_SEQ_STACK_EN
        op1(CL, 8'h80, 8'h80, 1'b0, "call_80");
        op1(CL, 8'h90, 8'h90, 1'b0, "call_90");
        op1(RT, 8'h00, 8'h81, 1'b0, "ret_81");
        op1(RT, 8'h00, 8'h11, 1'b0, "ret_11");
        op1(RT, 8'h00, 8'h12, 1'b1, "ret_underflow");
        op1(NX, 8'h00, 8'h13, 1'b1, "err_sticky");
`else
        op1(CL, 8'h80, 8'h11, 1'b0, "call_as_next");
        op1(CL, 8'h90, 8'h12, 1'b0, "call_as_next2");
        op1(RT, 8'h00, 8'h13, 1'b0, "ret_as_next");
        op1(RT, 8'h00, 8'h14, 1'b0, "ret_as_next2");
        op1(RT, 8'h00, 8'h15, 1'b0, "ret_as_next3");
        op1(NX, 8'h00, 8'h16, 1'b0, "next_16");
`endif
        // Five CALLs from empty, then four RETs.
        step(1'b1, 1'b1, NX, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, SI, 1'b0, "reset_clr");
        op1(NX, 8'h00, 8'h00, 1'b0, "idle_exit2");
`ifdef PC_SEQ_STACK_EN
        op1(CL, 8'hA0, 8'hA0, 1'b0, "call5_1");
        op1(CL, 8'hB0, 8'hB0, 1'b0, "call5_2");
        op1(CL, 8'hC0, 8'hC0, 1'b0, "call5_3");
        op1(CL, 8'hD0, 8'hD0, 1'b0, "call5_4");
        op1(CL, 8'hE0, 8'hD1, 1'b1, "call5_overflow");
        op1(RT, 8'h00, 8'hC1, 1'b1, "ret4_1");
        op1(RT, 8'h00, 8'hB1, 1'b1, "ret4_2");
        op1(RT, 8'h00, 8'hA1, 1'b1, "ret4_3");
        op1(RT, 8'h00, 8'h01, 1'b1, "ret4_4");
`else
        for (int i = 0; i < 5; i++) begin
            op1(CL, 8'hA0, 8'(i + 1), 1'b0, "call_off");
        end
        for (int i = 0; i < 4; i++) begin
            op1(RT, 8'h00, 8'(i + 6), 1'b0, "ret_off");
        end
`endif
        // Reset in the same cycle as a CALL at depth 2.
        step(1'b1, 1'b1, NX, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, SI, 1'b0, "reset_mid0");
        op1(NX, 8'h00, 8'h00, 1'b0, "idle_exit3");
`ifdef PC_SEQ_STACK_EN
        op1(CL, 8'h80, 8'h80, 1'b0, "callr_1");
        op1(CL, 8'h90, 8'h90, 1'b0, "callr_2");
`else
        op1(CL, 8'h80, 8'h01, 1'b0, "callr_1");
        op1(CL, 8'h90, 8'h02, 1'b0, "callr_2");
`endif
        step(1'b1, 1'b1, CL, 8'hA0, 1'b0, 1'b0, 1'b0, 8'h00, SI, 1'b0, "reset_mid_call");
        op1(NX, 8'h00, 8'h00, 1'b0, "idle_exit4");
`ifdef PC_SEQ_STACK_EN
        op1(RT, 8'h00, 8'h01, 1'b1, "ret_after_reset");
        op1(NX, 8'h00, 8'h02, 1'b1, "next_after");
`else
        op1(RT, 8'h00, 8'h01, 1'b0, "ret_after_reset");
        op1(NX, 8'h00, 8'h02, 1'b0, "next_after");
`endif
        bus.op_valid = 1'b0;
        // Let the monitor drain, bounded.
        for (int i = 0; i < 20; i++) begin
            if (sb_q.size() > 0) begin
                @(negedge clk);
            end
        end
        #2;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d records left, want 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
